i2c_target_regfile: RTL and testbench

Parametrised I2C target (slave) with an on-chip byte register file, replacing the fixed 7'h20 / 16-register target datapath. Synchronizes raw SCL/SDA, detects START/STOP/repeated START, decodes a configurable 7-bit address, and supports pointer-addressed multi-byte writes and reads with auto-increment. Registers are exported flat to the rest of the chip. A local-side write port is provided, and the block drives SDA open-drain only.

---
 rtl/i2c_target_regfile.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a pointer-addressed byte register file and a local write port.
// Define I2C_TARGET_GENERAL_CALL_EN to also accept general-call writes (address byte 8'h00).
module i2c_target_regfile #(
   parameter logic [6:0] TARGET_ADDR = 7'h20,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        PW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   input  logic                  local_we,
   input  logic [PW-1:0]         local_addr,
   input  logic [7:0]            local_wdata,
   output logic [8*NUM_REGS-1:0] regs_packed,
   output logic                  busy,
   output logic                  i2c_wr_pulse,
   output logic [PW-1:0]         i2c_wr_addr,
   output logic                  local_collision
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
   } state_t;

   state_t                      state_q, state_d;
   logic [SYNC_STAGES-1:0]      scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic                        scl_prev_q, sda_prev_q;
   logic [3:0]                  cnt_q, cnt_d;
   logic [7:0]                  sh_q, sh_d;
   logic [PW-1:0]               ptr_q, ptr_d;
   logic                        busy_q, busy_d;
   logic                        oe_q, oe_d;
   logic                        wr_pulse_q, wr_pulse_d;
   logic [PW-1:0]               wr_addr_q, wr_addr_d;
   logic [7:0]                  wr_data_q, wr_data_d;
   logic                        coll_q, coll_d;
   logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic addr_match, ptr_ok, local_ok;
   logic [PW-1:0] ptr_inc;

   assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
   assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise   = scl_s & ~scl_prev_q;
   assign scl_fall   = ~scl_s & scl_prev_q;
   assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

`ifdef I2C_TARGET_GENERAL_CALL_EN
   assign addr_match = (sh_q[7:1] == TARGET_ADDR) || (sh_q == 8'h00);
`else
   assign addr_match = (sh_q[7:1] == TARGET_ADDR);
`endif

   assign ptr_ok  = {1'b0, sh_q} < 9'(NUM_REGS);
   assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

   // Power-of-two register counts decode every local index, so no range check exists there.
   if ((1 << PW) == NUM_REGS) begin : g_pow2
      assign local_ok = 1'b1;
   end else begin : g_npow2
      assign local_ok = (local_addr < PW'(NUM_REGS));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      busy_d     = busy_q;
      oe_d       = oe_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         S_ADDR, S_PTR: begin
            if (scl_rise) begin
               sh_d  = {sh_q[6:0], sda_s};
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
               if (state_q == S_ADDR && addr_match) begin
                  state_d = S_ADDR_ACK;
                  oe_d    = 1'b1;
                  busy_d  = 1'b1;
               end else if (state_q == S_PTR && ptr_ok) begin
                  state_d = S_PTR_ACK;
                  ptr_d   = sh_q[PW-1:0];
                  oe_d    = 1'b1;
               end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
               end
            end
         end
         S_ADDR_ACK: begin
            if (scl_fall) begin
               cnt_d = '0;
               if (sh_q[0]) begin
                  state_d = S_RD;
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
               end else begin
                  state_d = S_PTR;
                  oe_d    = 1'b0;
               end
            end
         end
         S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
               state_d = S_WR;
               oe_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         S_WR: begin
            if (scl_rise) begin
               sh_d  = {sh_q[6:0], sda_s};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = {sh_q[6:0], sda_s};
                  ptr_d      = ptr_inc;
               end
            end else if (scl_fall && cnt_q == 4'd8) begin
               state_d = S_WR_ACK;
               oe_d    = 1'b1;
            end
         end
         S_RD: begin
            if (scl_rise) begin
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  state_d = S_RD_ACK;
                  oe_d    = 1'b0;
               end else begin
                  oe_d = ~sh_q[3'd7 - cnt_q[2:0]];
               end
            end
         end
         S_RD_ACK: begin
            // Only an ACKed rise keeps us here, so any later fall means "send the next byte".
            if (scl_rise && sda_s) begin
               state_d = S_IGNORE;
               busy_d  = 1'b0;
            end else if (scl_fall) begin
               state_d = S_RD;
               ptr_d   = ptr_inc;
               sh_d    = regs_q[ptr_inc];
               oe_d    = ~regs_q[ptr_inc][7];
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
      if (stop_det) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d = S_ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end
   end

   // An I2C commit always takes the register port; a coincident local write is dropped.
   always_comb begin
      regs_d = regs_q;
      coll_d = 1'b0;
      if (wr_pulse_q) begin
         regs_d[wr_addr_q] = wr_data_q;
         coll_d            = local_we;
      end else if (local_we && local_ok) begin
         regs_d[local_addr] = local_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         cnt_q      <= '0;
         sh_q       <= '0;
         ptr_q      <= '0;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         coll_q     <= 1'b0;
         regs_q     <= '0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         oe_q       <= oe_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         coll_q     <= coll_d;
         regs_q     <= regs_d;
      end
   end

   assign sda_oe          = oe_q;
   assign busy            = busy_q;
   assign i2c_wr_pulse    = wr_pulse_q;
   assign i2c_wr_addr     = wr_addr_q;
   assign local_collision = coll_q;
   assign regs_packed     = regs_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-level bus controller, a directed vector table,
// hand-written corner sequences and random transactions against a register/pointer model.
module tb_i2c_target_regfile;
   localparam int Q = 5;   // quarter SCL period in clocks

   logic         clock = 1'b0, reset = 1'b1;
   logic         scl_in = 1'b1, sda_m = 1'b1, sda_in;
   logic         local_we = 1'b0;
   logic [3:0]   local_addr = '0;
   logic [7:0]   local_wdata = '0;
   logic         sda_oe, busy, i2c_wr_pulse, local_collision;
   logic [3:0]   i2c_wr_addr;
   logic [127:0] regs_packed;

   assign sda_in = sda_m & ~sda_oe;
   always #5 clock = ~clock;

   i2c_target_regfile #(.TARGET_ADDR(7'h20), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .local_we(local_we), .local_addr(local_addr), .local_wdata(local_wdata),
      .regs_packed(regs_packed), .busy(busy), .i2c_wr_pulse(i2c_wr_pulse),
      .i2c_wr_addr(i2c_wr_addr), .local_collision(local_collision));

   int n_cmp = 0, n_bad = 0;
   logic [7:0] m_regs [16];
   int m_ptr = 0;
   int exp_wr[$], got_wr[$];
   int chk_idx = 0, coll_cnt = 0;

   always @(negedge clock) if (i2c_wr_pulse) got_wr.push_back(int'(i2c_wr_addr));
   always @(negedge clock) if (local_collision) coll_cnt++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] m_pack();
      logic [127:0] p;
      for (int i = 0; i < 16; i++) p[8*i +: 8] = m_regs[i];
      return p;
   endfunction

   task automatic check_wr();
      check("wr_pulse_count", got_wr.size(), exp_wr.size());
      for (int k = chk_idx; k < exp_wr.size() && k < got_wr.size(); k++)
         check("wr_pulse_addr", got_wr[k], exp_wr[k]);
      chk_idx = exp_wr.size();
   endtask

   task automatic wq();
      repeat (Q) @(negedge clock);
   endtask
   task automatic bus_start();
      sda_m = 1'b1; wq(); scl_in = 1'b1; wq(); sda_m = 1'b0; wq(); scl_in = 1'b0; wq();
   endtask
   task automatic bus_stop();
      sda_m = 1'b0; wq(); scl_in = 1'b1; wq(); sda_m = 1'b1; wq();
   endtask
   task automatic write_bit(input bit b);
      sda_m = b; wq(); scl_in = 1'b1; wq(); wq(); scl_in = 1'b0; wq();
   endtask
   task automatic read_bit(output bit b);
      sda_m = 1'b1; wq(); scl_in = 1'b1; wq(); b = sda_in; wq(); scl_in = 1'b0; wq();
   endtask
   task automatic write_byte(input logic [7:0] d, output bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask
   task automatic read_byte(output logic [7:0] d, input bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
      write_bit(~ack);
   endtask
   task automatic local_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clock); local_we = 1'b1; local_addr = a; local_wdata = d;
      @(negedge clock); local_we = 1'b0;
      m_regs[a] = d;
   endtask

   function automatic bit m_wr_addr_ok(input logic [7:0] a);
      bit ok;
      ok = (a[7:1] == 7'h20) && !a[0];
`ifdef I2C_TARGET_GENERAL_CALL_EN
      ok = ok || (a == 8'h00);
`endif
      return ok;
   endfunction

   // Write transaction: address, pointer, then nd data bytes; every ACK predicted from the model.
   task automatic txn_write(input logic [7:0] a, input logic [7:0] p, input int nd,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      logic [7:0] dd [3];
      bit ack, alive;
      dd[0] = d0; dd[1] = d1; dd[2] = d2;
      bus_start();
      alive = m_wr_addr_ok(a);
      write_byte(a, ack);
      check("wr_addr_ack", ack, alive);
      alive = alive && (p < 16);
      write_byte(p, ack);
      check("wr_ptr_ack", ack, alive);
      if (alive) m_ptr = p;
      for (int k = 0; k < nd; k++) begin
         write_byte(dd[k], ack);
         check("wr_data_ack", ack, alive);
         if (alive) begin
            m_regs[m_ptr] = dd[k];
            exp_wr.push_back(m_ptr);
            m_ptr = (m_ptr + 1) % 16;
         end
      end
      bus_stop();
      check("wr_busy_end", busy, 0);
      check("wr_regs", regs_packed, m_pack());
      check_wr();
   endtask

   task automatic txn_read(input logic [7:0] a, input int n);
      logic [7:0] d;
      bit ack;
      bus_start();
      write_byte(a, ack);
      check("rd_addr_ack", ack, a == 8'h41);
      if (a == 8'h41) begin
         for (int k = 0; k < n; k++) begin
            read_byte(d, k < n - 1);
            check("rd_data", d, m_regs[m_ptr]);
            if (k < n - 1) m_ptr = (m_ptr + 1) % 16;
         end
         check("rd_release", sda_oe, 0);
      end
      bus_stop();
      check("rd_busy_end", busy, 0);
   endtask

   typedef struct {
      logic [7:0] a, p, d;
      bit         ea, ep, ed;
      int         idx;
      logic [7:0] val;
   } vec_t;
   vec_t tbl [7];

   initial begin
      logic [7:0] d;
      bit ack, seen;
      int cc0;

      tbl[0] = '{8'h40, 8'h03, 8'hA5, 1'b1, 1'b1, 1'b1, 3, 8'hA5};
      tbl[1] = '{8'h42, 8'h06, 8'h11, 1'b0, 1'b0, 1'b0, 6, 8'h00};
      tbl[2] = '{8'h40, 8'h10, 8'h22, 1'b1, 1'b0, 1'b0, 0, 8'h00};
      tbl[3] = '{8'h40, 8'h0F, 8'h3C, 1'b1, 1'b1, 1'b1, 15, 8'h3C};
`ifdef I2C_TARGET_GENERAL_CALL_EN
      tbl[4] = '{8'h00, 8'h01, 8'h77, 1'b1, 1'b1, 1'b1, 1, 8'h77};
`else
      tbl[4] = '{8'h00, 8'h01, 8'h77, 1'b0, 1'b0, 1'b0, 1, 8'h00};
`endif
      tbl[5] = '{8'h01, 8'h02, 8'h99, 1'b0, 1'b0, 1'b0, 2, 8'h00};
      tbl[6] = '{8'h40, 8'hFF, 8'h12, 1'b1, 1'b0, 1'b0, 15, 8'h3C};
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_pulse", i2c_wr_pulse, 0);
      check("rst_wr_addr", i2c_wr_addr, 0);
      check("rst_collision", local_collision, 0);
      check("rst_regs", regs_packed, 0);

      for (int i = 0; i < 7; i++) begin
         bus_start();
         write_byte(tbl[i].a, ack); check("tbl_addr_ack", ack, tbl[i].ea);
         write_byte(tbl[i].p, ack); check("tbl_ptr_ack", ack, tbl[i].ep);
         write_byte(tbl[i].d, ack); check("tbl_data_ack", ack, tbl[i].ed);
         bus_stop();
         check("tbl_reg", regs_packed[8*tbl[i].idx +: 8], tbl[i].val);
         check("tbl_busy", busy, 0);
         if (tbl[i].ed) begin
            m_regs[tbl[i].p] = tbl[i].d;
            exp_wr.push_back(int'(tbl[i].p));
            m_ptr = (tbl[i].p + 1) % 16;
         end
      end
      check_wr();

      // Multi-byte write with busy observed mid-transaction.
      bus_start();
      write_byte(8'h40, ack); check("a_addr_ack", ack, 1);
      write_byte(8'h03, ack); check("a_ptr_ack", ack, 1);
      check("a_busy_mid", busy, 1);
      write_byte(8'hA5, ack); check("a_d0_ack", ack, 1);
      write_byte(8'h5A, ack); check("a_d1_ack", ack, 1);
      bus_stop();
      check("a_busy_end", busy, 0);
      check("a_reg3", regs_packed[31:24], 8'hA5);
      check("a_reg4", regs_packed[39:32], 8'h5A);
      m_regs[3] = 8'hA5; m_regs[4] = 8'h5A; m_ptr = 5;
      exp_wr.push_back(3); exp_wr.push_back(4);
      check_wr();

      // Pointer set, repeated START, read across the wrap point.
      local_write(4'd15, 8'hC3);
      local_write(4'd0, 8'h81);
      bus_start();
      write_byte(8'h40, ack); check("b_addr_ack", ack, 1);
      write_byte(8'h0F, ack); check("b_ptr_ack", ack, 1);
      bus_start();
      write_byte(8'h41, ack); check("b_raddr_ack", ack, 1);
      read_byte(d, 1'b1); check("b_rd0", d, 8'hC3);
      read_byte(d, 1'b0); check("b_rd1", d, 8'h81);
      check("b_release", sda_oe, 0);
      bus_stop();
      check("b_busy_end", busy, 0);
      m_ptr = 0;

      // Local write landing in the same cycle as an I2C commit.
      local_write(4'd5, 8'h55);
      cc0 = coll_cnt;
      bus_start();
      write_byte(8'h40, ack); check("c_addr_ack", ack, 1);
      write_byte(8'h02, ack); check("c_ptr_ack", ack, 1);
      seen = 1'b0;
      fork
         write_byte(8'h6B, ack);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clock);
               if (i2c_wr_pulse) begin seen = 1'b1; break; end
            end
            if (seen) begin
               local_we = 1'b1; local_addr = 4'd5; local_wdata = 8'hEE;
               @(negedge clock);
               local_we = 1'b0;
               check("c_reg2_next", regs_packed[23:16], 8'h6B);
               check("c_coll_hi", local_collision, 1);
               @(negedge clock);
               check("c_coll_lo", local_collision, 0);
            end
         end
      join
      check("c_pulse_seen", seen, 1);
      check("c_data_ack", ack, 1);
      bus_stop();
      m_regs[2] = 8'h6B; exp_wr.push_back(2); m_ptr = 3;
      check("c_regs", regs_packed, m_pack());
      check("c_coll_count", coll_cnt - cc0, 1);
      check_wr();

      // Reset while the target is pulling SDA low during a read.
      local_write(4'(m_ptr), 8'h3C);
      bus_start();
      write_byte(8'h41, ack); check("d_addr_ack", ack, 1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (sda_oe) begin seen = 1'b1; break; end
      end
      check("d_oe_driven", seen, 1);
      #2 reset = 1'b1;
      #1;
      check("d_oe_async", sda_oe, 0);
      check("d_regs_clr", regs_packed, 0);
      check("d_busy_clr", busy, 0);
      scl_in = 1'b1; sda_m = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      repeat (3) @(negedge clock);
      txn_write(8'h40, 8'h07, 1, 8'h9D, 8'h00, 8'h00);
      txn_read(8'h41, 2);

      // Random traffic against the model.
      for (int t = 0; t < 30; t++) begin
         logic [7:0] a;
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            local_write(4'($urandom_range(0, 15)), 8'($urandom));
         end else if (r < 6) begin
            case ($urandom_range(0, 5))
               0: a = 8'h42;
               1: a = 8'h00;
               2: a = 8'h60;
               default: a = 8'h40;
            endcase
            txn_write(a, 8'($urandom_range(0, 19)), int'($urandom_range(0, 3)),
                      8'($urandom), 8'($urandom), 8'($urandom));
         end else begin
            a = ($urandom_range(0, 4) == 0) ? 8'h43 : 8'h41;
            txn_read(a, int'($urandom_range(1, 3)));
         end
      end
      check("final_regs", regs_packed, m_pack());
      check_wr();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
